// File: rtl/cci_sequencer.sv
// Camera-control register sequencer: walks a command ROM and drives the
// i2c_master byte handshake for register writes, read-verify, polls and delays.
module cci_sequencer #(
    parameter logic [7:0]  DEVICE_ADDRESS    = 8'h6c,
    parameter int unsigned REG_ADDR_BYTES    = 2,
    parameter int unsigned DATA_BYTES        = 1,
    parameter int unsigned ROM_ADDR_WIDTH    = 8,
    parameter int unsigned DELAY_UNIT_CYCLES = 1000,
    parameter int unsigned RETRY_LIMIT       = 3,
    parameter int unsigned POLL_LIMIT        = 255
) (
    input  logic                                         clk_in,
    input  logic                                         reset_n,
    input  logic                                         start,
    input  logic [ROM_ADDR_WIDTH-1:0]                    seq_base,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         error,
    output logic [2:0]                                   err_code,
    output logic [ROM_ADDR_WIDTH-1:0]                    err_index,
    output logic [ROM_ADDR_WIDTH-1:0]                    rom_addr,
    input  logic [3+8*REG_ADDR_BYTES+8*DATA_BYTES-1:0]   rom_data,
    output logic [7:0]                                   address,
    output logic                                         transfer_start,
    output logic                                         transfer_continues,
    output logic [7:0]                                   data_tx,
    input  logic                                         transfer_ready,
    input  logic                                         interrupt,
    input  logic                                         nack,
    input  logic                                         address_err,
    input  logic [7:0]                                   data_rx
);

    localparam int unsigned AW  = 8 * REG_ADDR_BYTES;
    localparam int unsigned DW  = 8 * DATA_BYTES;
    localparam int unsigned EW  = 3 + AW + DW;
    localparam int unsigned SW  = AW + DW;
    localparam int unsigned BCW = 3;
    localparam int unsigned UW  = $clog2(DELAY_UNIT_CYCLES + 1);
    localparam int unsigned WCW = DW + UW;
    localparam int unsigned RCW = $clog2(RETRY_LIMIT + 2);
    localparam int unsigned PCW = $clog2(POLL_LIMIT + 1);

    localparam logic [2:0] OP_END    = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_VERIFY = 3'd2;
    localparam logic [2:0] OP_POLL   = 3'd3;
    localparam logic [2:0] OP_DELAY  = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LOAD, S_DECODE, S_REQ,
        S_XFER, S_WAIT, S_CHECK, S_DONE, S_ERROR
    } state_e;

    state_e                    state_q, state_d;
    logic [EW-1:0]             ent_q, ent_d;
    logic [BCW-1:0]            byte_q, byte_d;
    logic                      rd_phase_q, rd_phase_d;
    logic [DW-1:0]             rx_q, rx_d;
    logic [RCW-1:0]            retry_q, retry_d;
    logic [PCW-1:0]            poll_q, poll_d;
    logic [WCW-1:0]            wait_q, wait_d;
    logic                      resume_q, resume_d;

    logic                      busy_d, done_d, error_d;
    logic [2:0]                err_code_d;
    logic [ROM_ADDR_WIDTH-1:0] err_index_d, rom_addr_d;
    logic [7:0]                address_d, data_tx_d;
    logic                      transfer_start_d, transfer_continues_d;

    logic [2:0]                op;
    logic [SW-1:0]             seq_bytes;
    logic [DW-1:0]             wdata;
    logic                      is_rd;
    logic [BCW-1:0]            nw;
    logic [BCW-1:0]            byte_nxt;
    logic                      adv, fail;
    logic [2:0]                fail_code;

    assign op        = ent_q[EW-1 -: 3];
    assign seq_bytes = ent_q[SW-1:0];
    assign wdata     = ent_q[DW-1:0];
    assign is_rd     = (op == OP_VERIFY) || (op == OP_POLL);
    assign nw        = is_rd ? BCW'(REG_ADDR_BYTES) : BCW'(REG_ADDR_BYTES + DATA_BYTES);
    assign byte_nxt  = byte_q + BCW'(1);

    // Byte k of {reg_addr, data}, MSB first.
    function automatic logic [7:0] tx_byte(input logic [SW-1:0] s, input logic [BCW-1:0] k);
        logic [SW-1:0] sh;
        sh = s << (32'(k) * 32'd8);
        return sh[SW-1 -: 8];
    endfunction

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= S_IDLE;
            ent_q              <= '0;
            byte_q             <= '0;
            rd_phase_q         <= 1'b0;
            rx_q               <= '0;
            retry_q            <= '0;
            poll_q             <= '0;
            wait_q             <= '0;
            resume_q           <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            err_code           <= '0;
            err_index          <= '0;
            rom_addr           <= '0;
            address            <= '0;
            data_tx            <= '0;
            transfer_start     <= 1'b0;
            transfer_continues <= 1'b0;
        end else begin
            state_q            <= state_d;
            ent_q              <= ent_d;
            byte_q             <= byte_d;
            rd_phase_q         <= rd_phase_d;
            rx_q               <= rx_d;
            retry_q            <= retry_d;
            poll_q             <= poll_d;
            wait_q             <= wait_d;
            resume_q           <= resume_d;
            busy               <= busy_d;
            done               <= done_d;
            error              <= error_d;
            err_code           <= err_code_d;
            err_index          <= err_index_d;
            rom_addr           <= rom_addr_d;
            address            <= address_d;
            data_tx            <= data_tx_d;
            transfer_start     <= transfer_start_d;
            transfer_continues <= transfer_continues_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        ent_d                = ent_q;
        byte_d               = byte_q;
        rd_phase_d           = rd_phase_q;
        rx_d                 = rx_q;
        retry_d              = retry_q;
        poll_d               = poll_q;
        wait_d               = wait_q;
        resume_d             = resume_q;
        busy_d               = busy;
        done_d               = 1'b0;
        error_d              = error;
        err_code_d           = err_code;
        err_index_d          = err_index;
        rom_addr_d           = rom_addr;
        address_d            = address;
        data_tx_d            = data_tx;
        transfer_start_d     = transfer_start;
        transfer_continues_d = transfer_continues;
        adv                  = 1'b0;
        fail                 = 1'b0;
        fail_code            = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    err_code_d = 3'd0;
                    rom_addr_d = seq_base;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                ent_d   = rom_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                retry_d    = '0;
                poll_d     = '0;
                rd_phase_d = 1'b0;
                case (op)
                    OP_END: begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                    OP_WRITE, OP_VERIFY, OP_POLL: state_d = S_REQ;
                    OP_DELAY: begin
                        if (wdata == '0) begin
                            adv = 1'b1;
                        end else begin
                            // Loaded one short so the next FETCH lands exactly data*unit after decode.
                            wait_d   = WCW'(wdata) * WCW'(DELAY_UNIT_CYCLES) - WCW'(1);
                            resume_d = 1'b0;
                            state_d  = S_WAIT;
                        end
                    end
                    default: begin
                        fail      = 1'b1;
                        fail_code = 3'd4;
                    end
                endcase
            end
            S_REQ: begin
                if (!interrupt && transfer_ready) begin
                    transfer_start_d     = 1'b1;
                    transfer_continues_d = 1'b1;
                    address_d            = {DEVICE_ADDRESS[7:1], 1'b0};
                    data_tx_d            = tx_byte(seq_bytes, '0);
                    byte_d               = '0;
                    rd_phase_d           = 1'b0;
                    state_d              = S_XFER;
                end
            end
            S_XFER: begin
                if (interrupt) begin
                    if ((!rd_phase_q && (nack || address_err)) || (rd_phase_q && address_err)) begin
                        transfer_start_d     = 1'b0;
                        transfer_continues_d = 1'b0;
                        if (retry_q == RCW'(RETRY_LIMIT)) begin
                            fail      = 1'b1;
                            fail_code = 3'd1;
                        end else begin
                            retry_d  = retry_q + RCW'(1);
                            wait_d   = WCW'(DELAY_UNIT_CYCLES) - WCW'(1);
                            resume_d = 1'b1;
                            state_d  = S_WAIT;
                        end
                    end else if (!rd_phase_q) begin
                        transfer_start_d = 1'b0;
                        if (byte_nxt < nw) begin
                            data_tx_d            = tx_byte(seq_bytes, byte_nxt);
                            transfer_continues_d = ((byte_nxt + BCW'(1)) < nw) || is_rd;
                            byte_d               = byte_nxt;
                        end else if (is_rd) begin
                            // Repeated start in read direction; no STOP in between.
                            transfer_start_d     = 1'b1;
                            address_d            = {DEVICE_ADDRESS[7:1], 1'b1};
                            transfer_continues_d = (DATA_BYTES > 1);
                            rd_phase_d           = 1'b1;
                            byte_d               = '0;
                        end else begin
                            transfer_continues_d = 1'b0;
                            adv                  = 1'b1;
                        end
                    end else begin
                        transfer_start_d = 1'b0;
                        rx_d             = DW'({rx_q, data_rx});
                        if (byte_nxt < BCW'(DATA_BYTES)) begin
                            transfer_continues_d = ((byte_nxt + BCW'(1)) < BCW'(DATA_BYTES));
                            byte_d               = byte_nxt;
                        end else begin
                            transfer_continues_d = 1'b0;
                            state_d              = S_CHECK;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (wait_q <= WCW'(1)) begin
                    if (resume_q) state_d = S_REQ;
                    else          adv     = 1'b1;
                end else begin
                    wait_d = wait_q - WCW'(1);
                end
            end
            S_CHECK: begin
                if (rx_q == wdata) begin
                    adv = 1'b1;
                end else if (op == OP_VERIFY) begin
                    fail      = 1'b1;
                    fail_code = 3'd2;
                end else if (poll_q == PCW'(POLL_LIMIT - 1)) begin
                    fail      = 1'b1;
                    fail_code = 3'd3;
                end else begin
                    poll_d   = poll_q + PCW'(1);
                    wait_d   = WCW'(DELAY_UNIT_CYCLES) - WCW'(1);
                    resume_d = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Step to the next entry; running off the end of the ROM is an error.
        if (adv) begin
            if (&rom_addr) begin
                fail      = 1'b1;
                fail_code = 3'd5;
            end else begin
                rom_addr_d = rom_addr + ROM_ADDR_WIDTH'(1);
                state_d    = S_FETCH;
            end
        end

        if (fail) begin
            error_d              = 1'b1;
            err_code_d           = fail_code;
            err_index_d          = rom_addr;
            busy_d               = 1'b0;
            transfer_start_d     = 1'b0;
            transfer_continues_d = 1'b0;
            state_d              = S_ERROR;
        end
    end

endmodule

// File: tb/tb_cci_sequencer.sv
// Directed bench for cci_sequencer: command ROM model plus a simple
// byte-level i2c_master model with scripted NACK and read responses.
module tb_cci_sequencer;

    localparam int unsigned RAW = 8;
    localparam int unsigned EW  = 27;
    localparam int unsigned DU  = 10;
    localparam int unsigned PL  = 4;

    logic           clk_in = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [RAW-1:0] seq_base = '0;
    logic           busy, done, error;
    logic [2:0]     err_code;
    logic [RAW-1:0] err_index, rom_addr;
    logic [EW-1:0]  rom_data;
    logic [7:0]     address, data_tx;
    logic           transfer_start, transfer_continues;
    logic           transfer_ready = 1'b0;
    logic           interrupt = 1'b0;
    logic           nack = 1'b0;
    logic           address_err = 1'b0;
    logic [7:0]     data_rx = 8'h00;

    cci_sequencer #(
        .DEVICE_ADDRESS(8'h6c), .REG_ADDR_BYTES(2), .DATA_BYTES(1),
        .ROM_ADDR_WIDTH(RAW), .DELAY_UNIT_CYCLES(DU), .RETRY_LIMIT(3), .POLL_LIMIT(PL)
    ) dut (
        .clk_in(clk_in), .reset_n(reset_n), .start(start), .seq_base(seq_base),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .err_index(err_index), .rom_addr(rom_addr), .rom_data(rom_data),
        .address(address), .transfer_start(transfer_start),
        .transfer_continues(transfer_continues), .data_tx(data_tx),
        .transfer_ready(transfer_ready), .interrupt(interrupt), .nack(nack),
        .address_err(address_err), .data_rx(data_rx)
    );

    always #5 clk_in = ~clk_in;

    int unsigned cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    logic [EW-1:0] rom_mem [256];
    always @(posedge clk_in) rom_data <= rom_mem[rom_addr];

    function automatic logic [EW-1:0] mk(input logic [2:0] op, input logic [15:0] a, input logic [7:0] d);
        return {op, a, d};
    endfunction

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // i2c_master model state and logs
    int          m_st = 0;
    int          m_cnt = 0;
    logic        m_rd = 1'b0, m_cont = 1'b0, m_nack = 1'b0;
    logic [7:0]  m_rx = 8'h00;
    logic        nack_mode = 1'b0;
    logic [7:0]  rd_resp [$];
    int          rd_idx = 0;
    logic [7:0]  wr_bytes [$];
    logic        wr_cont [$];
    int unsigned n_starts = 0, n_reads = 0, n_done = 0;
    int unsigned last_rd_cyc = 0, min_gap = 32'hffff_ffff;
    logic [7:0]  last_start_addr = 8'h00;

    task automatic begin_byte(input logic is_start);
        transfer_ready = 1'b0;
        m_st   = 1;
        m_cnt  = 3;
        m_cont = transfer_continues;
        m_nack = 1'b0;
        if (is_start) begin
            n_starts++;
            m_rd = address[0];
            last_start_addr = address;
            if (m_rd) begin
                n_reads++;
                if (n_reads > 1 && (cyc - last_rd_cyc) < min_gap) min_gap = cyc - last_rd_cyc;
                last_rd_cyc = cyc;
            end
        end
        if (m_rd) begin
            if (rd_resp.size() == 0)        m_rx = 8'h00;
            else if (rd_idx < rd_resp.size()) m_rx = rd_resp[rd_idx];
            else                            m_rx = rd_resp[rd_resp.size()-1];
            rd_idx++;
        end else begin
            wr_bytes.push_back(data_tx);
            wr_cont.push_back(transfer_continues);
            m_nack = nack_mode;
        end
    endtask

    always @(negedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            m_st = 0; transfer_ready = 1'b0; interrupt = 1'b0; nack = 1'b0; m_rd = 1'b0;
        end else begin
            case (m_st)
                0: begin
                    transfer_ready = 1'b1;
                    if (transfer_start) begin_byte(1'b1);
                end
                1: begin
                    if (m_cnt > 1) m_cnt--;
                    else begin
                        interrupt = 1'b1; nack = m_nack; data_rx = m_rx; m_st = 2;
                    end
                end
                default: begin
                    interrupt = 1'b0; nack = 1'b0;
                    if (!m_nack && m_cont) begin_byte(transfer_start);
                    else begin m_st = 0; transfer_ready = 1'b1; end
                end
            endcase
        end
    end

    always @(negedge clk_in) if (reset_n && done) n_done++;

    task automatic clear_logs();
        wr_bytes.delete(); wr_cont.delete(); rd_resp.delete();
        rd_idx = 0; n_starts = 0; n_reads = 0; n_done = 0;
        last_rd_cyc = 0; min_gap = 32'hffff_ffff;
    endtask

    task automatic run_seq(input logic [RAW-1:0] base, output int unsigned t0);
        @(negedge clk_in);
        seq_base = base; start = 1'b1; t0 = cyc + 1;
        @(negedge clk_in);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("rom_addr_after_start", 32'(rom_addr), 32'(base));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 5000) begin @(negedge clk_in); k++; end
        check({tag, "_timeout"}, 32'(busy), 0);
        repeat (3) @(negedge clk_in);
    endtask

    initial begin
        int unsigned t0, t1, t2, d;
        int k;
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned t0, t1, t2, d;
        int k;
        for (int i = 0; i < 256; i++) rom_mem[i] = mk(3'd0, 16'h0, 8'h0);

        // Reset state
        repeat (3) @(negedge clk_in);
        check("rst_busy", 32'(busy), 0);
        check("rst_flags", {29'b0, done, error, transfer_start}, 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_bus", {16'b0, address, data_tx}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_in);

        // Plain write then END
        clear_logs();
        rom_mem[8'h10] = mk(3'd1, 16'h0100, 8'h01);
        rom_mem[8'h11] = mk(3'd0, 16'h0, 8'h0);
        run_seq(8'h10, t0);
        wait_idle("wr");
        check("wr_nbytes", wr_bytes.size(), 3);
        check("wr_b0", 32'(wr_bytes[0]), 32'h01);
        check("wr_b1", 32'(wr_bytes[1]), 32'h00);
        check("wr_b2", 32'(wr_bytes[2]), 32'h01);
        check("wr_cont", {29'b0, wr_cont[0], wr_cont[1], wr_cont[2]}, 32'b110);
        check("wr_start_addr", 32'(last_start_addr), 32'h6c);
        check("wr_done", n_done, 1);
        check("wr_error", 32'(error), 0);

        // VERIFY mismatch
        clear_logs();
        rd_resp.push_back(8'h57);
        rom_mem[0] = mk(3'd2, 16'h300a, 8'h56);
        rom_mem[1] = mk(3'd1, 16'h1234, 8'h99);
        rom_mem[2] = mk(3'd0, 16'h0, 8'h0);
        run_seq(8'h00, t0);
        wait_idle("vfy");
        repeat (40) @(negedge clk_in);
        check("vfy_error", 32'(error), 1);
        check("vfy_code", 32'(err_code), 2);
        check("vfy_index", 32'(err_index), 0);
        check("vfy_starts", n_starts, 2);
        check("vfy_addr_bytes", {16'b0, wr_bytes[0], wr_bytes[1]}, 32'h300a);
        check("vfy_nwr", wr_bytes.size(), 2);
        check("vfy_done", n_done, 0);

        // POLL that matches on the third read
        clear_logs();
        rd_resp.push_back(8'h01); rd_resp.push_back(8'h01); rd_resp.push_back(8'h00);
        rom_mem[0] = mk(3'd3, 16'h0100, 8'h00);
        rom_mem[1] = mk(3'd1, 16'h0102, 8'h33);
        rom_mem[2] = mk(3'd0, 16'h0, 8'h0);
        run_seq(8'h00, t0);
        wait_idle("poll");
        check("poll_reads", n_reads, 3);
        check("poll_gap_ok", 32'(min_gap >= DU), 1);
        check("poll_nwr", wr_bytes.size(), 9);
        check("poll_next_entry", {8'b0, wr_bytes[6], wr_bytes[7], wr_bytes[8]}, 32'h010233);
        check("poll_error", 32'(error), 0);
        check("poll_done", n_done, 1);

        // NACK on every write: 1 + RETRY_LIMIT attempts
        clear_logs();
        nack_mode = 1'b1;
        rom_mem[0] = mk(3'd1, 16'h0100, 8'h01);
        rom_mem[1] = mk(3'd0, 16'h0, 8'h0);
        run_seq(8'h00, t0);
        wait_idle("nack");
        nack_mode = 1'b0;
        check("nack_attempts", n_starts, 4);
        check("nack_error", 32'(error), 1);
        check("nack_code", 32'(err_code), 1);
        check("nack_index", 32'(err_index), 0);

        // POLL timeout after POLL_LIMIT reads
        clear_logs();
        rd_resp.push_back(8'h01);
        rom_mem[0] = mk(3'd3, 16'h0100, 8'h00);
        run_seq(8'h00, t0);
        wait_idle("ptmo");
        check("ptmo_reads", n_reads, PL);
        check("ptmo_code", 32'(err_code), 3);

        // DELAY 5 units then DELAY 0
        clear_logs();
        rom_mem[0] = mk(3'd4, 16'h0, 8'd5);
        rom_mem[1] = mk(3'd4, 16'h0, 8'd0);
        rom_mem[2] = mk(3'd0, 16'h0, 8'h0);
        run_seq(8'h00, t0);
        t1 = 0; t2 = 0;
        for (k = 0; k < 300 && t2 == 0; k++) begin
            @(negedge clk_in);
            if (t1 == 0 && rom_addr == 8'd1) t1 = cyc;
            if (t2 == 0 && rom_addr == 8'd2) t2 = cyc;
        end
        d = t1 - t0;
        check("dly5_cycles", (d >= 51 && d <= 53) ? 32'd52 : d, 52);
        check("dly0_cycles", t2 - t1, 3);
        wait_idle("dly");
        check("dly_done", n_done, 1);
        check("dly_error", 32'(error), 0);

        // Asynchronous reset during the second byte, then replay
        clear_logs();
        rom_mem[0] = mk(3'd1, 16'h0100, 8'ha5);
        rom_mem[1] = mk(3'd0, 16'h0, 8'h0);
        run_seq(8'h00, t0);
        for (k = 0; k < 200 && wr_bytes.size() < 2; k++) @(negedge clk_in);
        check("rst_mid_reached", wr_bytes.size(), 2);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_ctl", {30'b0, transfer_start, transfer_continues}, 0);
        check("rst_mid_bus", {16'b0, address, data_tx}, 0);
        check("rst_mid_rom_addr", 32'(rom_addr), 0);
        repeat (2) @(negedge clk_in);
        reset_n = 1'b1;
        clear_logs();
        run_seq(8'h00, t0);
        wait_idle("replay");
        check("replay_nwr", wr_bytes.size(), 3);
        check("replay_bytes", {8'b0, wr_bytes[0], wr_bytes[1], wr_bytes[2]}, 32'h0100a5);
        check("replay_done", n_done, 1);

        // Illegal opcode at index 2
        clear_logs();
        rom_mem[0] = mk(3'd4, 16'h0, 8'd0);
        rom_mem[1] = mk(3'd4, 16'h0, 8'd0);
        rom_mem[2] = mk(3'd6, 16'h0, 8'h0);
        run_seq(8'h00, t0);
        wait_idle("illop");
        check("illop_error", 32'(error), 1);
        check("illop_code", 32'(err_code), 4);
        check("illop_index", 32'(err_index), 2);

        // Index wrap at the last ROM entry
        clear_logs();
        rom_mem[255] = mk(3'd4, 16'h0, 8'd0);
        run_seq(8'hff, t0);
        wait_idle("wrap");
        check("wrap_code", 32'(err_code), 5);
        check("wrap_index", 32'(err_index), 32'hff);
        check("wrap_done", n_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cci_sequencer.md
# cci_sequencer

Parametrised camera-control register sequencer. Walks a command list held in an external synchronous ROM and drives the I2C master's byte handshake to perform register writes, read-verify, poll-until-value and timed delays. Replaces per-sensor hard-wired init tables: register address width, data width, device address, retry and poll limits are parameters. Sits between the sensor power/mode controller (start/done/error) and `i2c_master`.

## Interface
- `DEVICE_ADDRESS`, 8'h6c, 8-bit I2C address; bit 0 is ignored and replaced by R/W.
- `REG_ADDR_BYTES`, 2, register address bytes, 1..2, sent MSB first.
- `DATA_BYTES`, 1, data bytes per register, 1..2, MSB first.
- `ROM_ADDR_WIDTH`, 8, command ROM index width.
- `DELAY_UNIT_CYCLES`, 1000, clk_in cycles per delay unit, ≥1.
- `RETRY_LIMIT`, 3, extra attempts per entry after NACK or address error.
- `POLL_LIMIT`, 255, maximum read attempts for one POLL entry, ≥1.
- Derived: `AW=8*REG_ADDR_BYTES`, `DW=8*DATA_BYTES`, `EW=3+AW+DW`. Entry is {opcode[2:0], reg_addr[AW-1:0], data[DW-1:0]}.

- `clk_in` in 1: sole clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; run a sequence starting at `seq_base`. Ignored while `busy`.
- `seq_base` in ROM_ADDR_WIDTH: first entry index, sampled on `start`.
- `busy` out 1: sequence running.
- `done` out 1: one-cycle pulse when an END entry completes.
- `error` out 1: sticky; cleared on the next accepted `start`.
- `err_code` out 3: 1 NACK exhausted, 2 verify mismatch, 3 poll timeout, 4 illegal opcode, 5 index wrap.
- `err_index` out ROM_ADDR_WIDTH: index of the failing entry.
- `rom_addr` out ROM_ADDR_WIDTH: ROM index (registered).
- `rom_data` in EW: ROM output, valid the cycle after `rom_addr` changes.
- `address` out 8, `transfer_start` out 1, `transfer_continues` out 1, `data_tx` out 8: drives to `i2c_master`.
- `transfer_ready`, `interrupt`, `nack`, `address_err` in 1, `data_rx` in 8: returns from `i2c_master`.

## Operation
- Opcodes:
  - 0 END: `done` pulse, return to IDLE.
  - 1 WRITE: write `data` to `reg_addr`.
  - 2 VERIFY: read `reg_addr`; compare with `data`.
  - 3 POLL: read `reg_addr` until it equals `data`.
  - 4 DELAY: wait `data`×DELAY_UNIT_CYCLES; `data`=0 completes immediately.
  - 5–7: error 4.
- States: IDLE → FETCH (drive `rom_addr`) → LOAD (latch `rom_data`) → DECODE → XFER / WAIT → CHECK → FETCH (index+1), or DONE/ERROR → IDLE.
- Byte handshake:
  - First byte starts when `transfer_ready`=1. Drive `transfer_start`=1, `address`={DEVICE_ADDRESS[7:1],0}, `data_tx`=first address byte.
  - Each subsequent byte is presented on the `interrupt` for the previous byte.
  - `transfer_continues`=1 whenever another byte follows without a STOP.
  - Read: after the last address byte's interrupt, drive `transfer_start`=1 with `address`={DEVICE_ADDRESS[7:1],1}. Capture `data_rx` on each data-byte interrupt, assembled MSB first.
  - `transfer_start` and `transfer_continues` hold until the next `interrupt`. `transfer_start` clears on that interrupt.
- Write phase: `interrupt` with `nack` or `address_err` aborts the transaction and drops both controls. The same entry retries after DELAY_UNIT_CYCLES idle. After RETRY_LIMIT retries: error 1.
- Read data phase: `nack` is ignored (the master NACKs the last byte itself).
- VERIFY mismatch: error 2, no retry.
- POLL mismatch: wait DELAY_UNIT_CYCLES, then re-read. Mismatch on attempt POLL_LIMIT: error 3. The retry counter is separate from the poll counter.
- Incrementing past index 2^ROM_ADDR_WIDTH−1 without END: error 5.
- ERROR latches `err_code` and `err_index`, drops `busy`, goes to IDLE.

## Timing
- Reset values:
  - all handshake outputs 0, `address`=0, `data_tx`=0;
  - `busy`=0, `done`=0, `error`=0, `err_code`=0, `err_index`=0, `rom_addr`=0;
  - state IDLE.
- `start` in cycle N: `busy`=1 and `rom_addr`=`seq_base` at N+1. Entry latched at N+2; decode at N+3.
- Entry-to-entry overhead: 3 cycles plus I2C time.
- Each delay unit is exactly DELAY_UNIT_CYCLES cycles (±1 cycle total per DELAY).
- `done` asserts the cycle after END decodes; `busy` falls in the same cycle.
- Reset mid-transaction: outputs return to reset values at once; I2C bus recovery is left to the master.
- `interrupt` and `transfer_ready` together: `interrupt` takes priority.
- `start` in the same cycle as `done`/error: ignored.

## Test plan
- 8'h6c, 2-byte address, 1-byte data; ROM {WRITE 0x0100←0x01, END}. Expect bytes 0x01, 0x00, 0x01; `transfer_continues` 1, 1, 0; `done` pulse; `error`=0.
- VERIFY 0x300a=0x56 with model returning 0x57 → `error`=1, `err_code`=2, `err_index`=0, no further I2C traffic.
- POLL 0x0100=0x00, model returns 0x01 twice then 0x00 → exactly 3 reads separated by ≥DELAY_UNIT_CYCLES, then the next entry runs.
- WRITE, device NACKs every address byte, RETRY_LIMIT=3 → 4 attempts, then `err_code`=1.
- DELAY `data`=5, DELAY_UNIT_CYCLES=10 → next FETCH 50±1 cycles after decode. `data`=0 → next FETCH immediately.
- `reset_n` low during the second data byte → all outputs reset asynchronously. Fresh `start` then replays from `seq_base`. Opcode 6 at index 2 → `err_code`=4, `err_index`=2.
